// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// index-width helpers used to size the bit counter.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // A 1-bit counter is still needed when WIDTH=1, so never return zero.
    function automatic int idx_width(input int width);
        return (clog2(width) < 1) ? 1 : clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder; the serial adder reuses one instance per bit.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (x & c_in) | (y & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, one result bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_c;

    fa_cell u_fa (
        .x     (x_q[idx_q]),
        .y     (y_q[idx_q]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new request directly so back-to-back ops cost WIDTH+1 cycles.
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_d[idx_q] = fa_s;
                carry_d    = fa_c;
                idx_d      = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    c_out_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    ovf_d   = carry_q ^ fa_c;
`endif
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign s     = s_q;
    assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver pushes expected sums computed
// with plain integer arithmetic; a negedge monitor pops and checks on every done.
module tb_serial_adder;

    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        int acc_cyc;
        int sum;
        int ovf;
        int a;
        int b;
        int ci;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   prev_done = -1;
    bit   b2b_mode = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: unsigned WIDTH+1-bit sum and signed-range overflow.
    function automatic exp_t model(input int a, input int b, input int ci);
        exp_t e;
        int sa;
        int sb;
        int ss;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        ss = sa + sb + ci;
        e.sum = a + b + ci;
        e.ovf = (ss > (1 << (W - 1)) - 1 || ss < -(1 << (W - 1))) ? 1 : 0;
        e.a = a;
        e.b = b;
        e.ci = ci;
        e.acc_cyc = cyc + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("op %0d+%0d+%0d -> c_out=%0d s=%0d (expected %0d)",
                         e.a, e.b, e.ci, c_out, s, e.sum);
                chk("sum", int'({c_out, s}), e.sum);
                chk("latency", cyc - e.acc_cyc, W);
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", int'(ovf), e.ovf);
`endif
                if (b2b_mode && prev_done >= 0)
                    chk("b2b_spacing", cyc - prev_done, W + 1);
                prev_done = cyc;
            end
        end
    end

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("busy_timeout", 1, 0);
    endtask

    task automatic issue(input int a, input int b, input int ci);
        wait_not_busy();
        x = W'(a);
        y = W'(b);
        c_in = ci[0];
        start = 1;
        exp_q.push_back(model(a, b, ci));
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 1, 0);
    endtask

    initial begin
        int n;
        rst = 1;
        start = 0;
        x = '0;
        y = '0;
        c_in = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_s", int'(s), 0);
        chk("rst_c_out", int'(c_out), 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", int'(ovf), 0);
`endif
        rst = 0;
        @(negedge clk);

        // 3+5: busy for exactly W cycles, then done
        issue(3, 5, 0);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, W);
        chk("done_after_busy", int'(done), 1);
        @(negedge clk);

        issue(7, 7, 1);
        wait_done();
        repeat (2) @(negedge clk);
        chk("hold_s", int'(s), 7);
        chk("hold_c_out", int'(c_out), 1);
        chk("idle_done_low", int'(done), 0);
        issue(0, 0, 0);
        wait_done();
        @(negedge clk);

        // start held high: only accepted when not busy
        wait_not_busy();
        prev_done = -1;
        b2b_mode = 1;
        x = 3'd1;
        y = 3'd2;
        c_in = 0;
        start = 1;
        for (int i = 0; i < 16; i++) begin
            if (!busy) exp_q.push_back(model(1, 2, 0));
            @(negedge clk);
        end
        start = 0;
        wait_done();
        @(negedge clk);
        b2b_mode = 0;

        // abort with reset in the 2nd RUN cycle
        issue(6, 1, 0);
        @(negedge clk);
        rst = 1;
        exp_q.delete();
        @(negedge clk);
        rst = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_s", int'(s), 0);
        chk("abort_c_out", int'(c_out), 0);
        repeat (6) @(negedge clk);

        // operands changed mid-RUN must not matter
        issue(2, 2, 0);
        x = 3'd7;
        y = 3'd5;
        wait_done();
        @(negedge clk);

`ifdef SERIAL_ADDER_OVF_EN
        issue(3, 1, 0);
        wait_done();
        @(negedge clk);
        issue(5, 5, 0);
        wait_done();
        @(negedge clk);
`endif

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 1)));
            x = W'($urandom);
            y = W'($urandom);
            c_in = 1'($urandom);
            start = 1'($urandom);
            repeat ($urandom_range(0, 1)) begin
                if (!busy && start) break;
                @(negedge clk);
            end
            start = 0;
        end

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. One full-adder cell is reused over WIDTH cycles, and a registered carry links the bits.
- It is the area-reduced counterpart to the parallel ripple adder: same operand/carry semantics, one result bit per clock.
- Operands are captured on a start pulse. The result is delivered with a one-cycle done pulse and held until the next operation.

Parameters:
- WIDTH, 3, operand/sum width in bits (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- x  input  WIDTH  operand A; captured when start is accepted.
- y  input  WIDTH  operand B; captured when start is accepted.
- c_in  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when s/c_out become valid.
- s  output  WIDTH  sum, registered.
- c_out  output  1  final carry, registered.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst). All state updates on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, s=0, c_out=0, ovf=0, idx=0, internal carry=0, operand registers=0.
- States:
  - IDLE: start=1 -> latch x, y, c_in; idx=0; carry=c_in; go to RUN.
  - RUN: each edge computes bit idx with the FA cell: s[idx] <= sum, carry <= cout, idx++.
    - When idx==WIDTH-1, c_out <= cout and the state goes to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 -> accept a new operation (same actions as IDLE) and go to RUN.
    - Otherwise go to IDLE.
- busy=1 exactly in RUN.
- Latency: start sampled at edge E0 -> done high in the cycle after edge E(WIDTH), i.e. WIDTH cycles after acceptance.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored, with no queuing. Changes on x/y/c_in during RUN have no effect.
- s and c_out keep the previous result until overwritten bit by bit in the next RUN.
  - s bits update progressively during RUN, so s is only valid when done=1 or in IDLE after done.
- Arithmetic: {c_out,s} = x + y + c_in, unsigned, WIDTH+1 bits, never truncated.
- rst=1 in any state, including mid-RUN, returns every register to its reset value on that edge. No done pulse is produced for the aborted operation.
- WIDTH=1: RUN lasts one cycle.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output ovf, registered at the MSB step: ovf <= (carry into MSB) XOR cout.
  - Valid together with done; reset to 0; held like s.
- Undefined: the ovf port and its logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package/header holds:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - The index width function clog2(WIDTH).
- One sub-module, fa_cell: combinational 1-bit full adder (x, y, c_in -> s, c_out). It is instantiated once; the top level holds the FSM, shift/index registers and carry flop.

Test Plan:
- WIDTH=3, x=3, y=5, c_in=0, start 1 cycle -> busy for 3 cycles, then done=1 with s=0, c_out=1; ovf=0 if enabled.
- x=7, y=7, c_in=1 -> s=7, c_out=1. Then x=0, y=0, c_in=0 -> s=0, c_out=0, done exactly 3 cycles after acceptance.
- start held high continuously with x=1, y=2 -> results s=3 on every done, done pulses spaced 4 cycles apart. Starts asserted during RUN are not accepted.
- Start x=6, y=1, then assert rst for 1 cycle in the 2nd RUN cycle -> next cycle busy=0, done=0, s=0, c_out=0. No done pulse follows.
- Operand change mid-RUN (x=2, y=2 accepted, then x=7 during RUN) -> s=4, c_out=0.
- OVF_EN build: x=3, y=1, c_in=0 -> s=4, c_out=0, ovf=1. x=5, y=5 -> s=2, c_out=1, ovf=1.
